// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner: raw pins in,
// debounced level and press/repeat pulses out.
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (output btn_raw, input btn_level, input btn_pulse);
  modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, counter debouncer and press/auto-repeat event FSM
// for the Temporizer push-buttons.
module button_conditioner #(
  parameter int               N_BTN        = 5,
  parameter int               DEBOUNCE_CYC = 1_000_000,
  parameter int               REPEAT_DLY   = 25_000_000,
  parameter int               REPEAT_PER   = 5_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 5'b00110
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int DLY_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam int PER_W = (REPEAT_PER > 1) ? $clog2(REPEAT_PER) : 1;
  localparam int REP_W = (DLY_W > PER_W) ? DLY_W : PER_W;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PER - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    DONE   = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [DB_W-1:0]  db_cnt_q  [N_BTN];
  logic [DB_W-1:0]  db_cnt_d  [N_BTN];
  logic [REP_W-1:0] rep_cnt_q [N_BTN];
  logic [REP_W-1:0] rep_cnt_d [N_BTN];
  state_t           state_q   [N_BTN];
  state_t           state_d   [N_BTN];

  // The FSM looks at the next debounced level so the press pulse lands in the
  // same cycle the level first reads 1, and a release suppresses any tick.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i]  = '0;
      rep_cnt_d[i] = rep_cnt_q[i];
      state_d[i]   = state_q[i];

      if (sync2[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end

      if (!level_d[i]) begin
        state_d[i]   = IDLE;
        rep_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (!level_q[i]) begin
              pulse_d[i]   = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = REPEAT_MASK[i] ? HOLD : DONE;
            end
          end
          HOLD: begin
            if (rep_cnt_q[i] == DLY_LAST) begin
              pulse_d[i]   = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = REPEAT;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
          REPEAT: begin
            if (rep_cnt_q[i] == PER_LAST) begin
              pulse_d[i]   = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
          DONE: begin
            rep_cnt_d[i] = '0;
          end
          default: begin
            state_d[i]   = IDLE;
            rep_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= IDLE;
      end
    end else begin
      sync1   <= bus.btn_raw;
      sync2   <= sync1;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;

endmodule
